// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, defaults and the holding-entry type for the
// register-file write-back arbiter.
package rf_wb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int DBG_PORT    = NUM_REQ_DEF - 1;
    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 32;

    // One buffered write: destination register and the value to write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Advance a round-robin index by one, wrapping at n.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_rr_arb.sv
// rf_wb_rr_arb: combinational round-robin picker. The pointer names the
// port with highest priority; the first requesting port at or after it wins.
module rf_wb_rr_arb
    import rf_wb_pkg::*;
#(
    parameter int N     = NUM_REQ_DEF,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan ports starting at the pointer and grant the first requester.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges NUM_REQ write-back requesters onto one registered
// register-file write port. Each port has a one-entry holding register;
// the highest-numbered port is the debug port.
// Optional build macro RF_WB_STATS_EN adds wr_count / stall_count outputs.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int NUM_REGS = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable_debug,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_dest,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                rg_wrt_en,
    output logic [REG_ADDR_W-1:0]               rg_wrt_dest,
    output logic [DATA_W-1:0]                   rg_wrt_data,
    output logic [NUM_REGS-1:0]                 pend_mask
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0]                         wr_count,
    output logic [31:0]                         stall_count
`endif
);

    localparam int DBG   = NUM_REQ - 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ready_en_reg keeps req_ready low during reset and rises on the first
    // edge after release.
    logic                     ready_en_reg;
    logic [PTR_W-1:0]         ptr_reg;
    logic [PTR_W-1:0]         ptr_next;
    logic [NUM_REQ-1:0]       hold_valid;
    wb_req_t [NUM_REQ-1:0]    hold_entry;
    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       grant_raw;
    logic [NUM_REQ-1:0]       grant;
    logic                     any_grant;
    logic [PTR_W-1:0]         grant_idx;
    wb_req_t                  grant_entry;
    logic                     rg_wrt_en_reg;
    logic [REG_ADDR_W-1:0]    rg_wrt_dest_reg;
    logic [DATA_W-1:0]        rg_wrt_data_reg;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            localparam bit IS_DBG = (gi == DBG);

            logic    valid_reg;
            wb_req_t entry_reg;
            logic    accept;

            // Debug mode narrows eligibility to the debug port only.
            assign elig[gi]      = valid_reg & (~enable_debug | IS_DBG);
            // A flush kills any non-debug grant picked in the same cycle.
            assign grant[gi]     = grant_raw[gi] & (~flush | IS_DBG);
            // Ready when empty or draining this cycle, except non-debug ports under flush.
            assign req_ready[gi] = ready_en_reg & (~flush | IS_DBG) & (~valid_reg | grant[gi]);
            assign accept        = req_valid[gi] & req_ready[gi];

            // Holding register: flush clears, a non-zero-dest beat loads, a grant frees.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    entry_reg <= '0;
                end else if (flush && !IS_DBG) begin
                    valid_reg <= 1'b0;
                end else if (accept && (req_dest[gi] != '0)) begin
                    valid_reg      <= 1'b1;
                    entry_reg.dest <= req_dest[gi];
                    entry_reg.data <= req_data[gi];
                end else if (grant[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign hold_valid[gi] = valid_reg;
            assign hold_entry[gi] = entry_reg;
        end
    endgenerate

    rf_wb_rr_arb #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req   (elig),
        .ptr   (ptr_reg),
        .grant (grant_raw)
    );

    // Encode the one-hot grant and select the granted entry.
    always_comb begin
        grant_idx   = '0;
        grant_entry = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx   = PTR_W'(i);
                grant_entry = hold_entry[i];
            end
        end
    end

    assign any_grant = |grant;

    // Pointer moves past the granted port, frozen in debug mode or when idle.
    always_comb begin
        ptr_next = ptr_reg;
        if (any_grant && !enable_debug) begin
            ptr_next = PTR_W'(rr_wrap_inc(int'(grant_idx), NUM_REQ));
        end
    end

    // Registers with a buffered write still waiting to issue.
    always_comb begin
        pend_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_REQ; p++) begin
                if (hold_valid[p] && (hold_entry[p].dest == REG_ADDR_W'(r))) begin
                    pend_mask[r] = 1'b1;
                end
            end
        end
    end

    // Pointer, ready enable and the registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg         <= '0;
            ready_en_reg    <= 1'b0;
            rg_wrt_en_reg   <= 1'b0;
            rg_wrt_dest_reg <= '0;
            rg_wrt_data_reg <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            ready_en_reg  <= 1'b1;
            rg_wrt_en_reg <= any_grant;
            if (any_grant) begin
                rg_wrt_dest_reg <= grant_entry.dest;
                rg_wrt_data_reg <= grant_entry.data;
            end
        end
    end

    assign rg_wrt_en   = rg_wrt_en_reg;
    assign rg_wrt_dest = rg_wrt_dest_reg;
    assign rg_wrt_data = rg_wrt_data_reg;

`ifdef RF_WB_STATS_EN
    logic [31:0] wr_count_reg;
    logic [31:0] stall_count_reg;
    logic        any_stall;

    assign any_stall = |(hold_valid & ~grant);

    // Saturating counts of issued writes and of cycles with a waiting entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_reg    <= '0;
            stall_count_reg <= '0;
        end else begin
            if (any_grant && (wr_count_reg != '1)) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end
            if (any_stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign wr_count    = wr_count_reg;
    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic against a
// behavioural model; expected writes go to a queue checked by a monitor.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    localparam int N     = 3;
    localparam int DBG   = N - 1;
    localparam int NREGS = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable_debug = 1'b0;
    logic                 flush = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0][4:0]    req_dest = '0;
    logic [N-1:0][31:0]   req_data = '0;
    logic [N-1:0]         req_ready;
    logic                 rg_wrt_en;
    logic [4:0]           rg_wrt_dest;
    logic [31:0]          rg_wrt_data;
    logic [NREGS-1:0]     pend_mask;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NUM_REQ(N), .NUM_REGS(NREGS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_debug (enable_debug),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rg_wrt_en    (rg_wrt_en),
        .rg_wrt_dest  (rg_wrt_dest),
        .rg_wrt_data  (rg_wrt_data),
        .pend_mask    (pend_mask)
    );

    int cmp_count = 0;
    int err_count = 0;

    wb_req_t exp_q[$];

    // Reference model: per-port buffered write, last granted port, ready enable.
    bit          m_valid[N];
    logic [4:0]  m_dest[N];
    logic [31:0] m_data[N];
    int          m_last;
    bit          m_ready_en;
    logic [N-1:0] m_acc;

    // Pending stimulus per port (held until accepted).
    bit          off_v[N];
    logic [4:0]  off_d[N];
    logic [31:0] off_x[N];
    logic [31:0] data_seq = 32'h1000_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_dest[i]  = '0;
            m_data[i]  = '0;
        end
        m_last     = N - 1;
        m_ready_en = 1'b0;
    endtask

    // Round robin: first eligible port after the last one granted.
    function automatic int model_grant();
        int p;
        for (int k = 0; k < N; k++) begin
            p = (m_last + 1 + k) % N;
            if (m_valid[p] && (!enable_debug || p == DBG)) begin
                if (flush && p != DBG) return -1;
                return p;
            end
        end
        return -1;
    endfunction

    task automatic offer(input int p, input logic [4:0] d, input logic [31:0] x);
        off_v[p] = 1'b1;
        off_d[p] = d;
        off_x[p] = x;
    endtask

    task automatic drive_offers();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = off_v[i];
            req_dest[i]  = off_v[i] ? off_d[i] : 5'd0;
            req_data[i]  = off_v[i] ? off_x[i] : 32'd0;
        end
    endtask

    // One clock cycle: check combinational outputs, predict, advance model.
    task automatic step();
        logic [N-1:0]     rdy;
        logic [NREGS-1:0] pm;
        int               g;
        wb_req_t          e;
        #1;
        g  = model_grant();
        pm = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = m_ready_en && !(flush && i != DBG) && (!m_valid[i] || g == i);
            if (m_valid[i]) pm[m_dest[i]] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(rdy));
        check("pend_mask", pend_mask, pm);
        if (g >= 0) begin
            e.dest = m_dest[g];
            e.data = m_data[g];
            exp_q.push_back(e);
        end
        m_acc = req_valid & rdy;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (flush && i != DBG) begin
                m_valid[i] = 1'b0;
            end else if (m_acc[i] && req_dest[i] != 5'd0) begin
                m_valid[i] = 1'b1;
                m_dest[i]  = req_dest[i];
                m_data[i]  = req_data[i];
            end else if (g == i) begin
                m_valid[i] = 1'b0;
            end
        end
        if (g >= 0 && !enable_debug) m_last = g;
        m_ready_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive_offers();
            step();
            for (int i = 0; i < N; i++) if (m_acc[i]) off_v[i] = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n        = 1'b0;
        enable_debug = 1'b0;
        flush        = 1'b0;
        for (int i = 0; i < N; i++) off_v[i] = 1'b0;
        drive_offers();
        #1;
        check("rst_wrt_en", 32'(rg_wrt_en), 32'd0);
        check("rst_wrt_dest", 32'(rg_wrt_dest), 32'd0);
        check("rst_wrt_data", rg_wrt_data, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_pend_mask", pend_mask, 32'd0);
        model_reset();
        exp_q.delete();
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: after each edge, a queued expectation means a write must appear now.
    task automatic monitor();
        wb_req_t     e;
        logic [4:0]  last_d = '0;
        logic [31:0] last_x = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                last_d = '0;
                last_x = '0;
                check("wrt_en_in_reset", 32'(rg_wrt_en), 32'd0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wrt_en", 32'(rg_wrt_en), 32'd1);
                check("wrt_dest", 32'(rg_wrt_dest), 32'(e.dest));
                check("wrt_data", rg_wrt_data, e.data);
                last_d = e.dest;
                last_x = e.data;
            end else begin
                check("wrt_en_idle", 32'(rg_wrt_en), 32'd0);
                check("wrt_dest_hold", 32'(rg_wrt_dest), 32'(last_d));
                check("wrt_data_hold", rg_wrt_data, last_x);
            end
        end
    endtask

    function automatic int model_busy();
        int c = exp_q.size();
        for (int i = 0; i < N; i++) c += int'(m_valid[i]) + int'(off_v[i]);
        return c;
    endfunction

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) off_v[i] = 1'b0;
        fork
            monitor();
        join_none
        @(negedge clk);
        do_reset(2);

        // Single write from port 0.
        run(1);
        offer(0, 5'd5, 32'hDEADBEEF);
        run(5);

        // All ports streaming for six cycles from a fresh pointer.
        do_reset(1);
        run(1);
        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!off_v[p]) begin
                    data_seq++;
                    offer(p, 5'(1 + p * 4 + c % 4), data_seq);
                end
            end
            run(1);
        end
        run(6);

        // Write to register 0 is swallowed.
        offer(1, 5'd0, 32'h0000_1234);
        run(4);

        // Debug mode: only the debug port issues until it drops.
        enable_debug = 1'b1;
        offer(0, 5'd3, 32'h0000_0003);
        offer(2, 5'd7, 32'h0000_0007);
        run(4);
        enable_debug = 1'b0;
        run(4);

        // Flush drops ports 0 and 1, debug entry survives.
        offer(0, 5'd11, 32'hAAAA_0000);
        offer(1, 5'd12, 32'hBBBB_0000);
        offer(2, 5'd9,  32'h9999_9999);
        run(1);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        run(4);

        // Reset with three entries pending.
        offer(0, 5'd1, 32'h0101_0101);
        offer(1, 5'd2, 32'h0202_0202);
        offer(2, 5'd4, 32'h0404_0404);
        run(1);
        do_reset(2);
        run(4);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset(1);
            end
            if ($urandom_range(0, 15) == 0) enable_debug = ~enable_debug;
            flush = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < N; p++) begin
                if (!off_v[p] && $urandom_range(0, 1) == 1) begin
                    offer(p, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            run(1);
        end

        // Drain with a bounded budget.
        enable_debug = 1'b0;
        flush        = 1'b0;
        for (int k = 0; k < 50 && model_busy() != 0; k++) run(1);
        run(2);
        check("drain_outstanding", 32'(model_busy()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
